jericalla_pipe: RTL and testbench

JERICALLA_PIPE -- requirements
Module: jericalla_pipe

---
 rtl/jericalla_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_jericalla_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jericalla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : jericalla_pipe
// Purpose  : Three-stage in-order datapath. Decode and register read are
//            combinational, buffer 1 executes, and buffer 2 handles memory
//            access and write-back. There are no hazard stalls: buffer 2
//            forwards into execute, and the register file writes through to
//            decode. A global freeze input holds every piece of state.
// Ports    : clk_jericalla     - sole clock, rising edge
//            rst_n_jericalla   - asynchronous active-low reset (RAM kept)
//            instruccion       - {RA2, RA1, WA, OP}
//            instr_valid       - instruccion is valid this cycle
//            instr_ready       - instruction accepted this cycle (= !stall)
//            stall_jericalla   - freeze the whole pipeline
//            zf_jericalla      - zero flag of the last retired ALU op
//            dataOut_jericalla - write-back value of the last ALU op or LW
//            retire_valid      - pulse per retired non-NOP instruction
//            retired_count     - wrapping count of retired non-NOPs
// Revision : 1.0 - initial release
// ============================================================================
module jericalla_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RAM_AW = 6,
  parameter int CNT_W  = 16,
  localparam int INSTR_W = 3*REG_AW+3
) (
  input  logic               clk_jericalla,
  input  logic               rst_n_jericalla,
  input  logic [INSTR_W-1:0] instruccion,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall_jericalla,
  output logic               zf_jericalla,
  output logic [DATA_W-1:0]  dataOut_jericalla,
  output logic               retire_valid,
  output logic [CNT_W-1:0]   retired_count
);

  localparam logic [2:0] c_op_nop = 3'b000;
  localparam logic [2:0] c_op_add = 3'b001;
  localparam logic [2:0] c_op_sub = 3'b010;
  localparam logic [2:0] c_op_and = 3'b011;
  localparam logic [2:0] c_op_or  = 3'b100;
  localparam logic [2:0] c_op_slt = 3'b101;
  localparam logic [2:0] c_op_sw  = 3'b110;
  localparam logic [2:0] c_op_lw  = 3'b111;

  localparam int c_nregs = 2**REG_AW;
  localparam int c_nwords = 2**RAM_AW;

  // Decode fields
  logic [2:0]        w_op;
  logic [REG_AW-1:0] w_wa;
  logic [REG_AW-1:0] w_ra1;
  logic [REG_AW-1:0] w_ra2;
  logic              w_accept;

  // Storage
  logic [DATA_W-1:0] r_regs [c_nregs];
  logic [DATA_W-1:0] r_ram  [c_nwords];

  // Buffer 1 (execute)
  logic              r_b1_valid;
  logic [2:0]        r_b1_op;
  logic [REG_AW-1:0] r_b1_wa;
  logic [REG_AW-1:0] r_b1_ra1;
  logic [REG_AW-1:0] r_b1_ra2;
  logic [DATA_W-1:0] r_b1_a;
  logic [DATA_W-1:0] r_b1_b;

  // Buffer 2 (memory / write-back)
  logic              r_b2_valid;
  logic [2:0]        r_b2_op;
  logic [REG_AW-1:0] r_b2_wa;
  logic [DATA_W-1:0] r_b2_res;
  logic [RAM_AW-1:0] r_b2_addr;
  logic [DATA_W-1:0] r_b2_sdata;

  // Outputs
  logic              r_zf;
  logic [DATA_W-1:0] r_data_out;
  logic              r_retire;
  logic [CNT_W-1:0]  r_cnt;

  // Combinational
  logic              w_b2_wr_reg;
  logic              w_b2_alu;
  logic              w_b2_retire;
  logic              w_fwd_ok;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;

  assign w_op  = instruccion[2:0];
  assign w_wa  = instruccion[REG_AW+2:3];
  assign w_ra1 = instruccion[2*REG_AW+2:REG_AW+3];
  assign w_ra2 = instruccion[INSTR_W-1:2*REG_AW+3];

  assign instr_ready = !stall_jericalla;
  assign w_accept    = instr_valid && instr_ready;

  // Buffer 2 classification. Everything except NOP and SW writes a register.
  assign w_b2_wr_reg = r_b2_valid && (r_b2_op != c_op_nop) && (r_b2_op != c_op_sw);
  assign w_b2_alu    = r_b2_valid && (r_b2_op != c_op_nop) && (r_b2_op != c_op_sw)
                       && (r_b2_op != c_op_lw);
  assign w_b2_retire = r_b2_valid && (r_b2_op != c_op_nop);

  // LW data comes straight from the asynchronous RAM read.
  assign w_wb_data = (r_b2_op == c_op_lw) ? r_ram[r_b2_addr] : r_b2_res;

  // R0 is hard-wired to zero, so a write aimed at it must neither commit nor
  // be forwarded.
  assign w_fwd_ok = w_b2_wr_reg && (r_b2_wa != '0);
  assign w_rf_we  = w_fwd_ok && !stall_jericalla;

  // Decode read with write-through from the write-back in progress.
  always_comb begin
    w_rd1 = r_regs[w_ra1];
    w_rd2 = r_regs[w_ra2];
    if (w_rf_we && (w_ra1 == r_b2_wa)) w_rd1 = w_wb_data;
    if (w_rf_we && (w_ra2 == r_b2_wa)) w_rd2 = w_wb_data;
    if (w_ra1 == '0) w_rd1 = '0;
    if (w_ra2 == '0) w_rd2 = '0;
  end

  // Execute operands with forwarding from buffer 2.
  assign w_a = (w_fwd_ok && (r_b1_ra1 == r_b2_wa)) ? w_wb_data : r_b1_a;
  assign w_b = (w_fwd_ok && (r_b1_ra2 == r_b2_wa)) ? w_wb_data : r_b1_b;

  always_comb begin
    w_alu = '0;
    case (r_b1_op)
      c_op_add: w_alu = w_a + w_b;
      c_op_sub: w_alu = w_a - w_b;
      c_op_and: w_alu = w_a & w_b;
      c_op_or:  w_alu = w_a | w_b;
      c_op_slt: w_alu = DATA_W'(w_a < w_b);
      default:  w_alu = '0;
    endcase
  end

  // Pipeline, register file and output state.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      r_b1_valid <= 1'b0;
      r_b1_op    <= c_op_nop;
      r_b1_wa    <= '0;
      r_b1_ra1   <= '0;
      r_b1_ra2   <= '0;
      r_b1_a     <= '0;
      r_b1_b     <= '0;
      r_b2_valid <= 1'b0;
      r_b2_op    <= c_op_nop;
      r_b2_wa    <= '0;
      r_b2_res   <= '0;
      r_b2_addr  <= '0;
      r_b2_sdata <= '0;
      r_zf       <= 1'b0;
      r_data_out <= '0;
      r_retire   <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < c_nregs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (!stall_jericalla) begin
      // A cycle without an accepted instruction loads a bubble.
      r_b1_valid <= w_accept;
      r_b1_op    <= w_op;
      r_b1_wa    <= w_wa;
      r_b1_ra1   <= w_ra1;
      r_b1_ra2   <= w_ra2;
      r_b1_a     <= w_rd1;
      r_b1_b     <= w_rd2;

      r_b2_valid <= r_b1_valid;
      r_b2_op    <= r_b1_op;
      r_b2_wa    <= r_b1_wa;
      r_b2_res   <= w_alu;
      r_b2_addr  <= w_a[RAM_AW-1:0];
      r_b2_sdata <= w_b;

      r_retire <= w_b2_retire;
      if (w_b2_retire) r_cnt <= r_cnt + CNT_W'(1);
      if (w_rf_we) r_regs[r_b2_wa] <= w_wb_data;
      if (w_b2_alu) r_zf <= (r_b2_res == '0);
      if (w_b2_wr_reg) r_data_out <= w_wb_data;
    end else begin
      // Nothing retires while frozen, so the retirement pulse must not
      // persist across a stall.
      r_retire <= 1'b0;
    end
  end

  // RAM has no reset; buffer 2 valid is cleared asynchronously, so an
  // in-flight SW is dropped when reset hits.
  always_ff @(posedge clk_jericalla) begin
    if (rst_n_jericalla && !stall_jericalla && r_b2_valid && (r_b2_op == c_op_sw)) begin
      r_ram[r_b2_addr] <= r_b2_sdata;
    end
  end

  assign zf_jericalla      = r_zf;
  assign dataOut_jericalla = r_data_out;
  assign retire_valid      = r_retire;
  assign retired_count     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jericalla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_jericalla_pipe
// Purpose  : Directed self-checking bench for jericalla_pipe. It uses a
//            2-bit retire counter so that wrap-around is exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jericalla_pipe;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int RAM_AW = 6;
  localparam int CNT_W  = 2;
  localparam int INSTR_W = 3*REG_AW+3;

  localparam logic [2:0] c_nop = 3'b000;
  localparam logic [2:0] c_add = 3'b001;
  localparam logic [2:0] c_sub = 3'b010;
  localparam logic [2:0] c_or  = 3'b100;
  localparam logic [2:0] c_slt = 3'b101;
  localparam logic [2:0] c_sw  = 3'b110;
  localparam logic [2:0] c_lw  = 3'b111;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [INSTR_W-1:0] instr = '0;
  logic               valid = 1'b0;
  logic               ready;
  logic               stall = 1'b0;
  logic               zf;
  logic [DATA_W-1:0]  dout;
  logic               rv;
  logic [CNT_W-1:0]   cnt;

  int                 n_checks = 0;
  int                 n_fail = 0;
  logic [CNT_W-1:0]   exp_cnt = '0;

  jericalla_pipe #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .RAM_AW(RAM_AW), .CNT_W(CNT_W)
  ) dut (
    .clk_jericalla     (clk),
    .rst_n_jericalla   (rst_n),
    .instruccion       (instr),
    .instr_valid       (valid),
    .instr_ready       (ready),
    .stall_jericalla   (stall),
    .zf_jericalla      (zf),
    .dataOut_jericalla (dout),
    .retire_valid      (rv),
    .retired_count     (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input int wa,
                                            input int ra1, input int ra2);
    return {5'(ra2), 5'(ra1), 5'(wa), op};
  endfunction

  // Advance one edge; sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [INSTR_W-1:0] i);
    instr = i;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  logic [INSTR_W-1:0] prog [7];
  logic               exp_rv [7];

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_zf", 64'(zf), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_rv", 64'(rv), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // ---------------- SUB giving zero ----------------
    dut.r_regs[1] = 32'd5;
    dut.r_regs[2] = 32'd5;
    issue(mk(c_sub, 3, 1, 2));            // edge N
    check("sub_rv_n", 64'(rv), 64'd0);
    tick();                               // N+1
    check("sub_rv_n1", 64'(rv), 64'd0);
    tick();                               // N+2
    exp_cnt++;
    check("sub_rv_n2", 64'(rv), 64'd1);
    check("sub_dout", 64'(dout), 64'd0);
    check("sub_zf", 64'(zf), 64'd1);
    check("sub_cnt", 64'(cnt), 64'(exp_cnt));

    // ---------------- back-to-back ADD with forwarding ----------------
    dut.r_regs[1] = 32'd5;
    dut.r_regs[2] = 32'd7;
    issue(mk(c_add, 3, 1, 2));
    issue(mk(c_add, 4, 3, 1));
    tick();
    exp_cnt++;
    check("add1_rv", 64'(rv), 64'd1);
    check("add1_dout", 64'(dout), 64'd12);
    check("add1_zf", 64'(zf), 64'd0);
    tick();
    exp_cnt++;
    check("add2_rv", 64'(rv), 64'd1);
    check("add2_dout", 64'(dout), 64'd17);
    check("add2_cnt", 64'(cnt), 64'(exp_cnt));
    check("add2_r4", 64'(dut.r_regs[4]), 64'd17);

    // ---------------- SW then LW with address wrap ----------------
    dut.r_regs[1] = 32'd66;
    dut.r_regs[2] = 32'hDEADBEEF;
    issue(mk(c_sw, 0, 1, 2));
    issue(mk(c_lw, 5, 1, 0));
    tick();
    exp_cnt++;
    check("sw_rv", 64'(rv), 64'd1);
    check("sw_dout_hold", 64'(dout), 64'd17);
    check("sw_ram2", 64'(dut.r_ram[2]), 64'hDEADBEEF);
    tick();
    exp_cnt++;
    check("lw_rv", 64'(rv), 64'd1);
    check("lw_dout", 64'(dout), 64'hDEADBEEF);
    check("lw_zf_hold", 64'(zf), 64'd0);
    check("lw_r5", 64'(dut.r_regs[5]), 64'hDEADBEEF);
    check("lw_cnt", 64'(cnt), 64'(exp_cnt));

    // ---------------- 3-cycle stall mid-stream ----------------
    issue(mk(c_add, 6, 3, 4));            // 12 + 17 = 29
    issue(mk(c_sub, 7, 6, 3));            // 29 - 12 = 17 (forwarded)
    stall = 1'b1;
    instr = mk(c_add, 8, 3, 4);           // offered but must be refused
    valid = 1'b1;
    #1;
    check("stall_ready", 64'(ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_rv", 64'(rv), 64'd0);
      check("stall_dout", 64'(dout), 64'hDEADBEEF);
      check("stall_cnt", 64'(cnt), 64'(exp_cnt));
    end
    stall = 1'b0;
    valid = 1'b0;
    #1;
    check("unstall_ready", 64'(ready), 64'd1);
    tick();
    exp_cnt++;
    check("res_add_rv", 64'(rv), 64'd1);
    check("res_add_dout", 64'(dout), 64'd29);
    tick();
    exp_cnt++;
    check("res_sub_rv", 64'(rv), 64'd1);
    check("res_sub_dout", 64'(dout), 64'd17);
    check("res_sub_cnt", 64'(cnt), 64'(exp_cnt));
    tick();
    tick();
    check("stall_r8_untouched", 64'(dut.r_regs[8]), 64'd0);
    check("stall_r7", 64'(dut.r_regs[7]), 64'd17);

    // ---------------- reset with instructions in flight ----------------
    dut.r_regs[9] = 32'h11111111;
    issue(mk(c_sw, 0, 0, 9));             // RAM[0] = 0x11111111
    tick();
    tick();
    check("pre_ram0", 64'(dut.r_ram[0]), 64'h11111111);
    dut.r_regs[10] = 32'h22222222;
    issue(mk(c_sw, 0, 0, 10));            // in flight, must be dropped
    issue(mk(c_add, 11, 3, 4));           // in flight, must be dropped
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", 64'(dout), 64'd0);
    check("arst_zf", 64'(zf), 64'd0);
    check("arst_rv", 64'(rv), 64'd0);
    check("arst_cnt", 64'(cnt), 64'd0);
    check("arst_ready", 64'(ready), 64'd1);
    tick();
    tick();
    check("arst_ram0", 64'(dut.r_ram[0]), 64'h11111111);
    check("arst_r11", 64'(dut.r_regs[11]), 64'd0);
    check("arst_r10", 64'(dut.r_regs[10]), 64'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    tick();

    // ---------------- NOP interleave, counter wrap, R0 ----------------
    dut.r_regs[1] = 32'd1;
    dut.r_regs[2] = 32'd2;
    prog[0] = mk(c_add, 3, 1, 2);  exp_rv[0] = 1'b1;
    prog[1] = mk(c_nop, 9, 1, 2);  exp_rv[1] = 1'b0;
    prog[2] = mk(c_add, 0, 1, 2);  exp_rv[2] = 1'b1;
    prog[3] = mk(c_add, 7, 0, 1);  exp_rv[3] = 1'b1;
    prog[4] = mk(c_nop, 0, 0, 0);  exp_rv[4] = 1'b0;
    prog[5] = mk(c_or,  4, 1, 2);  exp_rv[5] = 1'b1;
    prog[6] = mk(c_slt, 6, 1, 2);  exp_rv[6] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 7) begin
        instr = prog[k];
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      tick();
      if (k >= 2) begin
        check($sformatf("seq_rv%0d", k - 2), 64'(rv), 64'(exp_rv[k-2]));
        if (exp_rv[k-2]) exp_cnt++;
      end
    end
    valid = 1'b0;
    check("seq_cnt_wrap", 64'(cnt), 64'd1);
    check("seq_cnt_model", 64'(cnt), 64'(exp_cnt));
    check("seq_dout_slt", 64'(dout), 64'd1);
    check("seq_zf", 64'(zf), 64'd0);
    check("seq_r0", 64'(dut.r_regs[0]), 64'd0);
    check("seq_r7_no_r0_fwd", 64'(dut.r_regs[7]), 64'd1);
    check("seq_r3", 64'(dut.r_regs[3]), 64'd3);
    check("seq_r4_or", 64'(dut.r_regs[4]), 64'd3);
    check("seq_r6_slt", 64'(dut.r_regs[6]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
